// File: rtl/ctrl_multi_input_queue.sv
// Per-channel one-entry descriptor staging, round-robin arbitration into a shared
// show-ahead FIFO, and saturating accounting of descriptors dropped at staging.
module ctrl_multi_input_queue #(
  parameter  int CH_NUM   = 2,
  parameter  int BUFID_W  = 9,
  parameter  int INPORT_W = 4,
  parameter  int DEPTH    = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int DW       = 1 + INPORT_W + BUFID_W,
  localparam int CW       = $clog2(CH_NUM)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [CH_NUM*BUFID_W-1:0]    iv_pkt_bufid_ctrl,
  input  logic [CH_NUM*INPORT_W-1:0]   iv_pkt_inport_ctrl,
  input  logic [CH_NUM-1:0]            iv_mac_entry_hit_ctrl,
  input  logic [CH_NUM-1:0]            iv_pkt_bufid_wr_ctrl,
  input  logic                         i_fifo_rd,
  output logic [DW-1:0]                ov_fifo_rdata,
  output logic                         o_fifo_empty,
  output logic                         o_fifo_full,
  output logic [AW:0]                  ov_fifo_usedw,
  output logic                         o_drop_pulse,
  output logic [15:0]                  ov_drop_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CH_NUM-1:0] stg_v_q, stg_v_d;
  logic [DW-1:0]     stg_data_q [CH_NUM];
  logic [DW-1:0]     stg_data_d [CH_NUM];
  logic [CW-1:0]     last_grant_q, last_grant_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       usedw_q, usedw_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [DW-1:0]     mem_q [DEPTH];

  logic              rd_en;
  logic              can_wr;
  logic              found;
  logic              grant_vld;
  logic [CW-1:0]     grant_idx;
  logic [CW-1:0]     cand;
  logic [CH_NUM-1:0] grant_oh;
  logic [3:0]        drop_num;
  logic [16:0]       drop_sum;

  assign rd_en  = i_fifo_rd && (usedw_q != '0);
  // A full FIFO still accepts a write when the head is popped on the same edge.
  assign can_wr = (usedw_q != FULL_CNT) || rd_en;

  always_comb begin
    // NOTE: every combinational variable gets a default first, so no path can infer a latch.
    found     = 1'b0;
    grant_idx = '0;
    cand      = last_grant_q;
    grant_oh  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cand = (cand == CW'(CH_NUM - 1)) ? '0 : cand + CW'(1);
      if (!found && stg_v_q[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_vld = found && can_wr;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
    last_grant_d = grant_vld ? grant_idx : last_grant_q;
  end

  always_comb begin
    stg_v_d    = stg_v_q;
    stg_data_d = stg_data_q;
    drop_num   = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (iv_pkt_bufid_wr_ctrl[c]) begin
        if (!stg_v_q[c] || grant_oh[c]) begin
          stg_v_d[c]    = 1'b1;
          stg_data_d[c] = {iv_mac_entry_hit_ctrl[c],
                           iv_pkt_inport_ctrl[c*INPORT_W +: INPORT_W],
                           iv_pkt_bufid_ctrl[c*BUFID_W +: BUFID_W]};
        end else begin
          drop_num = drop_num + 4'd1;
        end
      end else if (grant_oh[c]) begin
        stg_v_d[c] = 1'b0;
      end
    end
    drop_sum     = {1'b0, drop_cnt_q} + {13'd0, drop_num};
    drop_cnt_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    drop_pulse_d = (drop_num != '0);
  end

  always_comb begin
    wr_ptr_d = grant_vld ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    usedw_d  = usedw_q;
    if (grant_vld && !rd_en)      usedw_d = usedw_q + (AW+1)'(1);
    else if (!grant_vld && rd_en) usedw_d = usedw_q - (AW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stg_v_q      <= '0;
      last_grant_q <= CW'(CH_NUM - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      usedw_q      <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      stg_v_q      <= stg_v_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      usedw_q      <= usedw_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  // NOTE: payload storage has no reset; stg_v_q and usedw_q alone decide what is valid.
  always_ff @(posedge i_clk) begin
    stg_data_q <= stg_data_d;
    if (grant_vld) mem_q[wr_ptr_q] <= stg_data_q[grant_idx];
  end

  assign ov_fifo_rdata = mem_q[rd_ptr_q];
  assign o_fifo_empty  = (usedw_q == '0);
  assign o_fifo_full   = (usedw_q == FULL_CNT);
  assign ov_fifo_usedw = usedw_q;
  assign o_drop_pulse  = drop_pulse_q;
  assign ov_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ctrl_multi_input_queue.sv
// Self-checking bench for ctrl_multi_input_queue: directed scenarios with a
// scoreboard queue of expected FIFO entries popped as the consumer reads them.
module tb_ctrl_multi_input_queue;

  localparam int CH_NUM   = 2;
  localparam int BUFID_W  = 9;
  localparam int INPORT_W = 4;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int DW       = 14;

  logic                       i_clk = 1'b0;
  logic                       i_rst_n = 1'b0;
  logic [CH_NUM*BUFID_W-1:0]  iv_pkt_bufid_ctrl = '0;
  logic [CH_NUM*INPORT_W-1:0] iv_pkt_inport_ctrl = '0;
  logic [CH_NUM-1:0]          iv_mac_entry_hit_ctrl = '0;
  logic [CH_NUM-1:0]          iv_pkt_bufid_wr_ctrl = '0;
  logic                       i_fifo_rd = 1'b0;
  logic [DW-1:0]              ov_fifo_rdata;
  logic                       o_fifo_empty;
  logic                       o_fifo_full;
  logic [AW:0]                ov_fifo_usedw;
  logic                       o_drop_pulse;
  logic [15:0]                ov_drop_cnt;

  logic [DW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  ctrl_multi_input_queue #(
    .CH_NUM(CH_NUM), .BUFID_W(BUFID_W), .INPORT_W(INPORT_W), .DEPTH(DEPTH)
  ) dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .iv_pkt_bufid_ctrl     (iv_pkt_bufid_ctrl),
    .iv_pkt_inport_ctrl    (iv_pkt_inport_ctrl),
    .iv_mac_entry_hit_ctrl (iv_mac_entry_hit_ctrl),
    .iv_pkt_bufid_wr_ctrl  (iv_pkt_bufid_wr_ctrl),
    .i_fifo_rd             (i_fifo_rd),
    .ov_fifo_rdata         (ov_fifo_rdata),
    .o_fifo_empty          (o_fifo_empty),
    .o_fifo_full           (o_fifo_full),
    .ov_fifo_usedw         (ov_fifo_usedw),
    .o_drop_pulse          (o_drop_pulse),
    .ov_drop_cnt           (ov_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] desc(input logic hit, input logic [3:0] inport,
                                         input logic [8:0] bufid);
    return {hit, inport, bufid};
  endfunction

  task automatic set_ch(input int ch, input logic [DW-1:0] d);
    iv_pkt_bufid_ctrl[ch*BUFID_W +: BUFID_W]    = d[BUFID_W-1:0];
    iv_pkt_inport_ctrl[ch*INPORT_W +: INPORT_W] = d[BUFID_W +: INPORT_W];
    iv_mac_entry_hit_ctrl[ch]                   = d[DW-1];
    iv_pkt_bufid_wr_ctrl[ch]                    = 1'b1;
  endtask

  task automatic clr_strobes();
    iv_pkt_bufid_wr_ctrl = '0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
  endtask

  // Pops n entries, comparing each head against the scoreboard before acknowledging it.
  task automatic drain(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      while (o_fifo_empty && waited < 20) begin
        tick();
        waited++;
      end
      if (o_fifo_empty) begin
        check({tag, "_wait_timeout"}, 32'(o_fifo_empty), 32'd0);
        return;
      end
      check({tag, "_data"}, 32'(ov_fifo_rdata), 32'(exp_q.pop_front()));
      i_fifo_rd = 1'b1;
      tick();
      i_fifo_rd = 1'b0;
    end
  endtask

  initial begin
    logic [DW-1:0] a;
    logic [DW-1:0] b;

    // Reset state
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    check("rst_empty", 32'(o_fifo_empty), 32'd1);
    check("rst_full", 32'(o_fifo_full), 32'd0);
    check("rst_usedw", 32'(ov_fifo_usedw), 32'd0);
    check("rst_drop_cnt", 32'(ov_drop_cnt), 32'd0);
    check("rst_drop_pulse", 32'(o_drop_pulse), 32'd0);

    // Single strobe latency
    set_ch(0, desc(1'b1, 4'h3, 9'h1A5));
    tick();
    clr_strobes();
    check("lat_e0_empty", 32'(o_fifo_empty), 32'd1);
    tick();
    check("lat_rdata", 32'(ov_fifo_rdata), 32'h27A5);
    check("lat_empty", 32'(o_fifo_empty), 32'd0);
    check("lat_usedw", 32'(ov_fifo_usedw), 32'd1);
    exp_q.push_back(14'h27A5);
    drain(1, "lat");
    check("lat_drained", 32'(ov_fifo_usedw), 32'd0);

    // Simultaneous strobes from reset: ch0 first, then ch1
    do_reset();
    a = desc(1'b0, 4'h0, 9'h011);
    b = desc(1'b1, 4'h1, 9'h122);
    set_ch(0, a);
    set_ch(1, b);
    tick();
    clr_strobes();
    tick();
    check("dual_usedw1", 32'(ov_fifo_usedw), 32'd1);
    check("dual_head", 32'(ov_fifo_rdata), 32'(a));
    tick();
    check("dual_usedw2", 32'(ov_fifo_usedw), 32'd2);
    check("dual_drops", 32'(ov_drop_cnt), 32'd0);
    exp_q.push_back(a);
    exp_q.push_back(b);
    drain(2, "dual");

    // Fill with 20 strobes on ch0: 1..16 queued, 17 staged, 18..20 dropped
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      set_ch(0, desc(i[0], 4'h0, 9'(i)));
      tick();
      if (i <= 17) exp_q.push_back(desc(i[0], 4'h0, 9'(i)));
      if (i >= 16) check($sformatf("fill_pulse_%0d", i), 32'(o_drop_pulse), 32'(i >= 18));
    end
    clr_strobes();
    check("fill_full", 32'(o_fifo_full), 32'd1);
    check("fill_usedw", 32'(ov_fifo_usedw), 32'd16);
    check("fill_drop_cnt", 32'(ov_drop_cnt), 32'd3);
    tick();
    check("fill_pulse_idle", 32'(o_drop_pulse), 32'd0);
    check("fill_hold_usedw", 32'(ov_fifo_usedw), 32'd16);

    // Read on a full FIFO while ch0 is staged: write and read together
    check("full_rd_head", 32'(ov_fifo_rdata), 32'(exp_q.pop_front()));
    i_fifo_rd = 1'b1;
    tick();
    i_fifo_rd = 1'b0;
    check("full_rd_usedw", 32'(ov_fifo_usedw), 32'd16);
    check("full_rd_next", 32'(ov_fifo_rdata), 32'(exp_q[0]));
    drain(16, "full_drain");
    check("full_drain_empty", 32'(o_fifo_empty), 32'd1);

    // Two-channel flood: 1 drop per edge until full, then 2 per edge
    do_reset();
    set_ch(0, desc(1'b0, 4'h0, 9'h055));
    set_ch(1, desc(1'b1, 4'h1, 9'h0AA));
    for (int k = 1; k <= 32776; k++) begin
      tick();
      if (k == 17) check("flood_cnt_e17", 32'(ov_drop_cnt), 32'd16);
      if (k == 20) check("flood_cnt_e20", 32'(ov_drop_cnt), 32'd22);
    end
    check("flood_cnt_fffe", 32'(ov_drop_cnt), 32'hFFFE);
    tick();
    check("sat_two_drops", 32'(ov_drop_cnt), 32'hFFFF);
    check("sat_pulse", 32'(o_drop_pulse), 32'd1);
    iv_pkt_bufid_wr_ctrl[1] = 1'b0;
    tick();
    clr_strobes();
    check("sat_hold", 32'(ov_drop_cnt), 32'hFFFF);

    // Mid-operation reset with 5 queued and ch1 staged
    do_reset();
    check("rst2_cnt_cleared", 32'(ov_drop_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      set_ch(0, desc(1'b0, 4'h0, 9'(9'h100 + i)));
      tick();
    end
    clr_strobes();
    set_ch(1, desc(1'b1, 4'h1, 9'h0F0));
    tick();
    clr_strobes();
    check("pre_rst_usedw", 32'(ov_fifo_usedw), 32'd5);
    i_rst_n = 1'b0;
    set_ch(0, desc(1'b1, 4'h0, 9'h1FF));
    tick();
    i_rst_n = 1'b1;
    clr_strobes();
    check("mid_rst_usedw", 32'(ov_fifo_usedw), 32'd0);
    check("mid_rst_empty", 32'(o_fifo_empty), 32'd1);
    check("mid_rst_full", 32'(o_fifo_full), 32'd0);
    check("mid_rst_cnt", 32'(ov_drop_cnt), 32'd0);
    check("mid_rst_pulse", 32'(o_drop_pulse), 32'd0);
    tick();
    tick();
    check("mid_rst_no_stale", 32'(ov_fifo_usedw), 32'd0);
    a = desc(1'b1, 4'h0, 9'h033);
    b = desc(1'b0, 4'h1, 9'h144);
    set_ch(0, a);
    set_ch(1, b);
    tick();
    clr_strobes();
    tick();
    check("mid_rst_order", 32'(ov_fifo_rdata), 32'(a));
    exp_q.push_back(a);
    exp_q.push_back(b);
    drain(2, "mid_rst");

    // Read while empty is ignored
    i_fifo_rd = 1'b1;
    tick();
    i_fifo_rd = 1'b0;
    check("empty_rd_usedw", 32'(ov_fifo_usedw), 32'd0);
    check("empty_rd_empty", 32'(o_fifo_empty), 32'd1);
    a = desc(1'b1, 4'h1, 9'h0C3);
    set_ch(1, a);
    tick();
    clr_strobes();
    tick();
    exp_q.push_back(a);
    drain(1, "empty_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
